// File: rtl/mdio_slave_22_45_backend_if.sv
// Register-bus interface between the MDIO slave backend (master) and the
// register file it accesses (slave). Single-beat request/acknowledge transfers.
interface mdio_slave_22_45_backend_if;
    logic        bus_req;
    logic        bus_we;
    logic        bus_c45;
    logic [4:0]  bus_devad;
    logic [15:0] bus_addr;
    logic [15:0] bus_wdata;
    logic        bus_ack;
    logic [15:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_c45, bus_devad, bus_addr, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_c45, bus_devad, bus_addr, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/mdio_slave_22_45_backend.sv
// MDIO slave transaction backend: decodes Clause 22 / Clause 45 frames from
// the frontend and turns them into single-beat register-bus accesses, returning
// read data to the frontend before the turnaround.
// Optional feature macro: MDIO_BACKEND_C45_EN. When undefined, the C45 address
// register and C45 decode are removed; C45 reads answer 16'hFFFF without a bus
// access and C45 writes / address frames are ignored.
module mdio_slave_22_45_backend #(
    parameter int RD_TIMEOUT = 12
) (
    input  logic        clk_25m,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [31:0] rx_data,
    input  logic        info_done,
    input  logic        data_done,
    output logic [15:0] resp_rdata,
    output logic        resp_ready,
    output logic        busy,
    output logic        timeout_err,
    mdio_slave_22_45_backend_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RESP,
        S_WR_WAIT,
        S_WR_REQ
    } state_e;

    // Frame kind latched at info_done. K_NULL_RD is a read that is answered
    // with all-ones without touching the bus (C45 read with C45 support off).
    typedef enum logic [2:0] {
        K_NONE,
        K_RD,
        K_PRI,
        K_WR,
        K_ADDR,
        K_NULL_RD
    } kind_e;

    localparam logic [3:0] TMO_LAST = 4'(RD_TIMEOUT - 1);

    state_e      state_q, state_d;
    kind_e       kind_q, kind_d;
    kind_e       dec_kind;
    logic        we_q, we_d;
    logic [4:0]  devad_q, devad_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        tmo_q, tmo_d;
    logic        bus_req;
`ifdef MDIO_BACKEND_C45_EN
    logic        c45_q, c45_d;
    logic        dec_c45;
    logic [15:0] addr_q, addr_d;
`endif

    // PHYAD is pre-qualified by the frontend and the TA bits carry no meaning here.
    logic unused_rx_bits;
    assign unused_rx_bits = ^{rx_data[27:23], rx_data[17:16]};

    // Classify the incoming frame header from ST and OP.
    always_comb begin
        dec_kind = K_NONE;
`ifdef MDIO_BACKEND_C45_EN
        dec_c45  = (rx_data[31:30] == 2'b00);
`endif
        case (rx_data[31:30])
            2'b01: begin
                case (rx_data[29:28])
                    2'b01:   dec_kind = K_WR;
                    2'b10:   dec_kind = K_RD;
                    default: dec_kind = K_NONE;
                endcase
            end
            2'b00: begin
`ifdef MDIO_BACKEND_C45_EN
                case (rx_data[29:28])
                    2'b00:   dec_kind = K_ADDR;
                    2'b01:   dec_kind = K_WR;
                    2'b11:   dec_kind = K_RD;
                    default: dec_kind = K_PRI;
                endcase
`else
                if (rx_data[29]) dec_kind = K_NULL_RD;
`endif
            end
            default: dec_kind = K_NONE;
        endcase
    end

    // Next-state and output logic of the transaction FSM.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        kind_d     = kind_q;
        we_d       = we_q;
        devad_d    = devad_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        cnt_d      = '0;
        tmo_d      = 1'b0;
        bus_req    = 1'b0;
        resp_ready = 1'b0;
`ifdef MDIO_BACKEND_C45_EN
        c45_d      = c45_q;
        addr_d     = addr_q;
`endif

        case (state_q)
            S_RD_REQ: begin
                if (kind_q == K_NULL_RD) begin
                    rdata_d = 16'hFFFF;
                    state_d = S_RESP;
                end else begin
                    bus_req = 1'b1;
                    if (bus.bus_ack) begin
                        rdata_d = bus.bus_rdata;
                        state_d = S_RESP;
                    end else if (cnt_q == TMO_LAST) begin
                        rdata_d = 16'hFFFF;
                        tmo_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            S_RESP: begin
                resp_ready = 1'b1;
`ifdef MDIO_BACKEND_C45_EN
                if (kind_q == K_PRI) addr_d = addr_q + 16'd1;
`endif
                state_d = S_IDLE;
            end
            S_WR_WAIT: begin
                if (data_done) begin
`ifdef MDIO_BACKEND_C45_EN
                    if (kind_q == K_ADDR) begin
                        addr_d  = rx_data[15:0];
                        state_d = S_IDLE;
                    end else begin
                        wdata_d = rx_data[15:0];
                        state_d = S_WR_REQ;
                    end
`else
                    wdata_d = rx_data[15:0];
                    state_d = S_WR_REQ;
`endif
                end
            end
            S_WR_REQ: begin
                bus_req = 1'b1;
                if (bus.bus_ack) begin
                    state_d = S_IDLE;
                end else if (cnt_q == TMO_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: ;
        endcase

        // A header in IDLE starts a frame; in WR_WAIT it aborts the pending one.
        if (info_done && (state_q == S_IDLE || state_q == S_WR_WAIT)) begin
            if (dec_kind == K_NONE) begin
                state_d = S_IDLE;
            end else begin
                kind_d  = dec_kind;
                we_d    = (dec_kind == K_WR);
                devad_d = rx_data[22:18];
`ifdef MDIO_BACKEND_C45_EN
                c45_d   = dec_c45;
`endif
                state_d = (dec_kind == K_WR || dec_kind == K_ADDR) ? S_WR_WAIT : S_RD_REQ;
            end
        end

        // Synchronous clear returns every register to its reset value.
        if (!enable) begin
            state_d = S_IDLE;
            kind_d  = K_NONE;
            we_d    = 1'b0;
            devad_d = '0;
            wdata_d = '0;
            rdata_d = '0;
            cnt_d   = '0;
            tmo_d   = 1'b0;
`ifdef MDIO_BACKEND_C45_EN
            c45_d   = 1'b0;
            addr_d  = '0;
`endif
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            kind_q  <= K_NONE;
            we_q    <= 1'b0;
            devad_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
`ifdef MDIO_BACKEND_C45_EN
            c45_q   <= 1'b0;
            addr_q  <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed by the combinational block.
            state_q <= state_d;
            kind_q  <= kind_d;
            we_q    <= we_d;
            devad_q <= devad_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
`ifdef MDIO_BACKEND_C45_EN
            c45_q   <= c45_d;
            addr_q  <= addr_d;
`endif
        end
    end

    assign resp_rdata     = rdata_q;
    assign busy           = (state_q != S_IDLE);
    assign timeout_err    = tmo_q;
    assign bus.bus_req    = bus_req;
    assign bus.bus_we     = we_q;
    assign bus.bus_devad  = devad_q;
    assign bus.bus_wdata  = wdata_q;
`ifdef MDIO_BACKEND_C45_EN
    assign bus.bus_c45    = c45_q;
    assign bus.bus_addr   = c45_q ? addr_q : 16'h0000;
`else
    assign bus.bus_c45    = 1'b0;
    assign bus.bus_addr   = 16'h0000;
`endif

endmodule

// File: tb/tb_mdio_slave_22_45_backend.sv
// Self-checking bench for mdio_slave_22_45_backend: table of frame vectors with
// an acknowledging bus model, a response scoreboard, and hand-written sequences
// for enable-clear and frame abort. Adapts to MDIO_BACKEND_C45_EN.
module tb_mdio_slave_22_45_backend;

    localparam int RD_TIMEOUT = 12;

    logic        clk_25m;
    logic        rst_n;
    logic        enable;
    logic [31:0] rx_data;
    logic        info_done;
    logic        data_done;
    logic [15:0] resp_rdata;
    logic        resp_ready;
    logic        busy;
    logic        timeout_err;

    mdio_slave_22_45_backend_if bus_if ();

    mdio_slave_22_45_backend #(.RD_TIMEOUT(RD_TIMEOUT)) dut (
        .clk_25m    (clk_25m),
        .rst_n      (rst_n),
        .enable     (enable),
        .rx_data    (rx_data),
        .info_done  (info_done),
        .data_done  (data_done),
        .resp_rdata (resp_rdata),
        .resp_ready (resp_ready),
        .busy       (busy),
        .timeout_err(timeout_err),
        .bus        (bus_if)
    );

    typedef struct {
        string       name;
        logic [1:0]  st;
        logic [1:0]  op;
        logic [4:0]  regad;
        logic [15:0] data;
        bit          has_data;
        int          ack_dly;    // bus_req cycle index of the ack, -1 = never
        logic [15:0] bus_rd;
        bit          exp_req;
        bit          exp_we;
        bit          exp_c45;
        logic [15:0] exp_addr;
        bit          exp_resp;
        logic [15:0] exp_rdata;
        bit          exp_tmo;
    } vec_t;

    typedef struct {
        logic [15:0] rdata;
        logic        tmo;
    } resp_t;

    int    n_checks = 0;
    int    n_errors = 0;
    resp_t exp_q[$];
    vec_t  vecs[$];

    initial begin
        clk_25m = 1'b0;
        forever #20 clk_25m = ~clk_25m;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_25m);
        @(negedge clk_25m);
    endtask

    function automatic vec_t mk(input string name, input logic [1:0] st, input logic [1:0] op,
                                input logic [4:0] regad, input logic [15:0] data, input bit has_data,
                                input int ack_dly, input logic [15:0] bus_rd, input bit exp_req,
                                input bit exp_we, input bit exp_c45, input logic [15:0] exp_addr,
                                input bit exp_resp, input logic [15:0] exp_rdata, input bit exp_tmo);
        vec_t v;
        v.name = name;       v.st = st;           v.op = op;
        v.regad = regad;     v.data = data;       v.has_data = has_data;
        v.ack_dly = ack_dly; v.bus_rd = bus_rd;   v.exp_req = exp_req;
        v.exp_we = exp_we;   v.exp_c45 = exp_c45; v.exp_addr = exp_addr;
        v.exp_resp = exp_resp; v.exp_rdata = exp_rdata; v.exp_tmo = exp_tmo;
        return v;
    endfunction

    // Scoreboard: every resp_ready strobe must match the oldest expected response.
    always @(negedge clk_25m) begin
        if (rst_n && resp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_resp: got resp_ready=1 rdata=%h, expected no response", resp_rdata);
            end else begin
                resp_t r;
                r = exp_q.pop_front();
                check("sb_rdata", {16'h0, resp_rdata}, {16'h0, r.rdata});
                check("sb_tmo", {31'h0, timeout_err}, {31'h0, r.tmo});
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int    n;
        resp_t r;
        if (v.exp_resp) begin
            r.rdata = v.exp_rdata;
            r.tmo   = v.exp_tmo;
            exp_q.push_back(r);
        end
        rx_data   = {v.st, v.op, 5'h01, v.regad, 2'b10, v.data};
        info_done = 1'b1;
        cyc();
        info_done = 1'b0;
        if (v.has_data) begin
            check({v.name, "_no_req_before_data"}, {31'h0, bus_if.bus_req}, 32'h0);
            data_done = 1'b1;
            cyc();
            data_done = 1'b0;
        end
        n = 0;
        if (v.exp_req) begin
            while (bus_if.bus_req && n < 40) begin
                check({v.name, "_we"}, {31'h0, bus_if.bus_we}, {31'h0, v.exp_we});
                check({v.name, "_c45"}, {31'h0, bus_if.bus_c45}, {31'h0, v.exp_c45});
                check({v.name, "_devad"}, {27'h0, bus_if.bus_devad}, {27'h0, v.regad});
                check({v.name, "_addr"}, {16'h0, bus_if.bus_addr}, {16'h0, v.exp_addr});
                if (v.exp_we)
                    check({v.name, "_wdata"}, {16'h0, bus_if.bus_wdata}, {16'h0, v.data});
                if (n == v.ack_dly) begin
                    bus_if.bus_ack   = 1'b1;
                    bus_if.bus_rdata = v.bus_rd;
                end
                cyc();
                bus_if.bus_ack   = 1'b0;
                bus_if.bus_rdata = 16'h0;
                n++;
            end
            check({v.name, "_req_cycles"}, n, (v.ack_dly >= 0) ? v.ack_dly + 1 : RD_TIMEOUT);
        end else begin
            check({v.name, "_no_req"}, {31'h0, bus_if.bus_req}, 32'h0);
            if (!v.has_data) cyc();
            check({v.name, "_still_no_req"}, {31'h0, bus_if.bus_req}, 32'h0);
        end
        check({v.name, "_resp_ready"}, {31'h0, resp_ready}, {31'h0, v.exp_resp});
        check({v.name, "_timeout_err"}, {31'h0, timeout_err}, {31'h0, v.exp_tmo});
        cyc();
        check({v.name, "_resp_once"}, {31'h0, resp_ready}, 32'h0);
        check({v.name, "_tmo_once"}, {31'h0, timeout_err}, 32'h0);
        cyc();
        check({v.name, "_idle"}, {31'h0, busy}, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resp_t r;
        rst_n            = 1'b0;
        enable           = 1'b1;
        rx_data          = '0;
        info_done        = 1'b0;
        data_done        = 1'b0;
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = 16'h0;

        //                name               st     op     reg    data     hd ack bus_rd   req we c45 addr    rsp rdata  tmo
        vecs.push_back(mk("c22_rd",          2'b01, 2'b10, 5'h02, 16'h0000, 0, 3, 16'h1234, 1, 0, 0, 16'h0000, 1, 16'h1234, 0));
        vecs.push_back(mk("c22_wr",          2'b01, 2'b01, 5'h1F, 16'h5A5A, 1, 0, 16'h0000, 1, 1, 0, 16'h0000, 0, 16'h0000, 0));
        vecs.push_back(mk("c22_rd_fast",     2'b01, 2'b10, 5'h00, 16'h0000, 0, 0, 16'hBEEF, 1, 0, 0, 16'h0000, 1, 16'hBEEF, 0));
        vecs.push_back(mk("c22_op00_ign",    2'b01, 2'b00, 5'h03, 16'h0000, 0,-1, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0000, 0));
        vecs.push_back(mk("c22_op11_ign",    2'b01, 2'b11, 5'h03, 16'h0000, 0,-1, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0000, 0));
        vecs.push_back(mk("st1x_ign",        2'b10, 2'b10, 5'h03, 16'h0000, 0,-1, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0000, 0));
        vecs.push_back(mk("c22_rd_tmo",      2'b01, 2'b10, 5'h0A, 16'h0000, 0,-1, 16'h0000, 1, 0, 0, 16'h0000, 1, 16'hFFFF, 1));
        vecs.push_back(mk("c22_rd_last_ack", 2'b01, 2'b10, 5'h0B, 16'h0000, 0,11, 16'h0F0F, 1, 0, 0, 16'h0000, 1, 16'h0F0F, 0));
        vecs.push_back(mk("c22_wr_tmo",      2'b01, 2'b01, 5'h0C, 16'h1357, 1,-1, 16'h0000, 1, 1, 0, 16'h0000, 0, 16'h0000, 1));
`ifdef MDIO_BACKEND_C45_EN
        vecs.push_back(mk("c45_addr",        2'b00, 2'b00, 5'h01, 16'h0800, 1,-1, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0000, 0));
        vecs.push_back(mk("c45_wr",          2'b00, 2'b01, 5'h01, 16'hABCD, 1, 0, 16'h0000, 1, 1, 1, 16'h0800, 0, 16'h0000, 0));
        vecs.push_back(mk("c45_addr_ffff",   2'b00, 2'b00, 5'h03, 16'hFFFF, 1,-1, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0000, 0));
        vecs.push_back(mk("c45_pri0",        2'b00, 2'b10, 5'h03, 16'h0000, 0, 1, 16'h1111, 1, 0, 1, 16'hFFFF, 1, 16'h1111, 0));
        vecs.push_back(mk("c45_pri1",        2'b00, 2'b10, 5'h03, 16'h0000, 0, 0, 16'h2222, 1, 0, 1, 16'h0000, 1, 16'h2222, 0));
        vecs.push_back(mk("c45_rd",          2'b00, 2'b11, 5'h03, 16'h0000, 0, 2, 16'h3333, 1, 0, 1, 16'h0001, 1, 16'h3333, 0));
`else
        vecs.push_back(mk("c45_rd_null",     2'b00, 2'b11, 5'h01, 16'h0000, 0,-1, 16'h0000, 0, 0, 0, 16'h0000, 1, 16'hFFFF, 0));
        vecs.push_back(mk("c45_pri_null",    2'b00, 2'b10, 5'h01, 16'h0000, 0,-1, 16'h0000, 0, 0, 0, 16'h0000, 1, 16'hFFFF, 0));
        vecs.push_back(mk("c45_wr_ign",      2'b00, 2'b01, 5'h01, 16'hABCD, 1,-1, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0000, 0));
        vecs.push_back(mk("c45_addr_ign",    2'b00, 2'b00, 5'h01, 16'h0800, 1,-1, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0000, 0));
`endif
        vecs.push_back(mk("c22_rd_after",    2'b01, 2'b10, 5'h11, 16'h0000, 0, 1, 16'hC0DE, 1, 0, 0, 16'h0000, 1, 16'hC0DE, 0));

        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();
        check("rst_resp_rdata", {16'h0, resp_rdata}, 32'h0);
        check("rst_resp_ready", {31'h0, resp_ready}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_timeout_err", {31'h0, timeout_err}, 32'h0);
        check("rst_bus_req", {31'h0, bus_if.bus_req}, 32'h0);
        check("rst_bus_we", {31'h0, bus_if.bus_we}, 32'h0);
        check("rst_bus_c45", {31'h0, bus_if.bus_c45}, 32'h0);
        check("rst_bus_devad", {27'h0, bus_if.bus_devad}, 32'h0);
        check("rst_bus_addr", {16'h0, bus_if.bus_addr}, 32'h0);
        check("rst_bus_wdata", {16'h0, bus_if.bus_wdata}, 32'h0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // enable dropped while a read waits on the bus: request withdrawn, no response
        rx_data   = {2'b01, 2'b10, 5'h01, 5'h07, 2'b10, 16'h0};
        info_done = 1'b1;
        cyc();
        info_done = 1'b0;
        check("en_req_up", {31'h0, bus_if.bus_req}, 32'h1);
        cyc();
        enable = 1'b0;
        cyc();
        check("en_req_dropped", {31'h0, bus_if.bus_req}, 32'h0);
        check("en_busy_clear", {31'h0, busy}, 32'h0);
        enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("en_no_resp", {31'h0, resp_ready}, 32'h0);
            cyc();
        end
        run_vec(mk("en_recover_rd", 2'b01, 2'b10, 5'h02, 16'h0, 0, 0, 16'h4321, 1, 0, 0, 16'h0, 1, 16'h4321, 0));

        // a new header while waiting for write data aborts the write
        rx_data   = {2'b01, 2'b01, 5'h01, 5'h04, 2'b10, 16'h0};
        info_done = 1'b1;
        cyc();
        r.rdata = 16'h7777;
        r.tmo   = 1'b0;
        exp_q.push_back(r);
        rx_data = {2'b01, 2'b10, 5'h01, 5'h06, 2'b10, 16'h0};
        cyc();
        info_done = 1'b0;
        check("abort_req", {31'h0, bus_if.bus_req}, 32'h1);
        check("abort_we", {31'h0, bus_if.bus_we}, 32'h0);
        check("abort_devad", {27'h0, bus_if.bus_devad}, 32'h6);
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = 16'h7777;
        cyc();
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = 16'h0;
        check("abort_resp_ready", {31'h0, resp_ready}, 32'h1);
        data_done = 1'b1;
        rx_data   = {16'h0, 16'h9999};
        cyc();
        data_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("abort_no_write", {31'h0, bus_if.bus_req}, 32'h0);
            cyc();
        end

        check("sb_empty", exp_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
